// File: rtl/data_cache_if.sv
// CPU-side and data-memory-side signals of the data cache.
// A request is accepted at the first posedge where stall=0; the CPU holds all cpu_* inputs while stall=1.
interface data_cache_if #(
  parameter int A_WIDTH = 32
);
  logic [A_WIDTH-1:0] cpu_a;
  logic               cpu_re;
  logic               cpu_we;
  logic [31:0]        cpu_wd;
  logic [31:0]        cpu_rd;
  logic               stall;
  logic [A_WIDTH-1:0] mem_a;
  logic               mem_we;
  logic [31:0]        mem_wd;
  logic [31:0]        mem_rd;

  modport master (
    output cpu_a, cpu_re, cpu_we, cpu_wd, mem_rd,
    input  cpu_rd, stall, mem_a, mem_we, mem_wd
  );

  modport slave (
    input  cpu_a, cpu_re, cpu_we, cpu_wd, mem_rd,
    output cpu_rd, stall, mem_a, mem_we, mem_wd
  );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with 4-word lines.
// Read hits answer combinationally; read misses stall while the line is fetched one word per cycle.
module data_cache #(
  parameter int A_WIDTH = 32,
  parameter int SETS    = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  data_cache_if.slave    bus,
  output logic [31:0]    hit_count_o,
  output logic [31:0]    miss_count_o,
  output logic           dbg_state_o
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = A_WIDTH - 4 - IDX_W;

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [31:0]        hit_q, miss_q;
  logic               valid_q [SETS];
  logic [TAG_W-1:0]   tag_q   [SETS];
  logic [31:0]        data_q  [SETS][4];

  logic [1:0]         word;
  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic               hit;
  logic               hit_inc, miss_inc, wr_hit, fill_we;
  logic               unused_low_bits;

  assign word = bus.cpu_a[3:2];
  assign idx  = bus.cpu_a[4+IDX_W-1:4];
  assign tag  = bus.cpu_a[A_WIDTH-1:4+IDX_W];
  assign hit  = valid_q[idx] && (tag_q[idx] == tag);
  assign unused_low_bits = ^bus.cpu_a[1:0];

  assign hit_count_o  = hit_q;
  assign miss_count_o = miss_q;
  assign dbg_state_o  = state_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bus.stall  = 1'b0;
    bus.cpu_rd = 32'h0;
    bus.mem_we = 1'b0;
    bus.mem_wd = bus.cpu_wd;
    bus.mem_a  = {bus.cpu_a[A_WIDTH-1:2], 2'b00};
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    wr_hit     = 1'b0;
    fill_we    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A store wins over a simultaneous load: write-only, no read, no counting.
        if (bus.cpu_we) begin
          bus.mem_we = 1'b1;
          wr_hit     = hit;
        end else if (bus.cpu_re) begin
          if (hit) begin
            bus.cpu_rd = data_q[idx][word];
            hit_inc    = 1'b1;
          end else begin
            bus.stall = 1'b1;
            miss_inc  = 1'b1;
            cnt_d     = 2'd0;
            state_d   = FILL;
          end
        end
      end
      FILL: begin
        bus.stall = 1'b1;
        bus.mem_a = {bus.cpu_a[A_WIDTH-1:4], cnt_q, 2'b00};
        fill_we   = 1'b1;
        cnt_d     = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      hit_q   <= 32'h0;
      miss_q  <= 32'h0;
      for (int s = 0; s < SETS; s++) valid_q[s] <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (hit_inc && (hit_q != 32'hFFFF_FFFF)) hit_q <= hit_q + 32'd1;
      if (miss_inc && (miss_q != 32'hFFFF_FFFF)) miss_q <= miss_q + 32'd1;
      if (fill_we && (cnt_q == 2'd3)) valid_q[idx] <= 1'b1;
    end
  end

  // Tags and data carry no reset; a fill aborted by reset leaves its line invalid.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (fill_we) begin
        data_q[idx][cnt_q] <= bus.mem_rd;
        if (cnt_q == 2'd3) tag_q[idx] <= tag;
      end else if (wr_hit) begin
        data_q[idx][word] <= bus.cpu_wd;
      end
    end
  end
endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed plan followed by randomized loads and stores.
module tb_data_cache;
  localparam int AW   = 32;
  localparam int SETS = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_cache_if #(.A_WIDTH(AW)) bus ();
  logic [31:0] hit_count, miss_count;
  logic        dbg_state;

  data_cache #(.A_WIDTH(AW), .SETS(SETS)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bus          (bus),
    .hit_count_o  (hit_count),
    .miss_count_o (miss_count),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- data memory (16 KiB window) ----------------
  logic [31:0] mem_arr [0:4095];
  logic        mem_init = 1'b1;

  function automatic logic [31:0] init_word(int i);
    if (i >= 32'h400 && i <= 32'h403) return 32'hA0 + 32'(i - 32'h400);
    return 32'h5EED_0000 ^ (32'(i) * 32'h9E37);
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 4096; i++) mem_arr[i] <= init_word(i);
    end else if (bus.mem_we) begin
      mem_arr[bus.mem_a[13:2]] <= bus.mem_wd;
    end
  end

  always_comb bus.mem_rd = mem_arr[bus.mem_a[13:2]];

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [0:4095];
  bit          m_valid [SETS];
  logic [27:0] m_line  [SETS];
  int unsigned m_hits, m_miss;
  logic [31:0] exp_q [$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) m_valid[s] = 1'b0;
    m_hits = 0;
    m_miss = 0;
    exp_q.delete();
  endtask

  task automatic check_counters(input string tag);
    bus.cpu_re = 1'b0;
    bus.cpu_we = 1'b0;
    @(negedge clk);
    check({tag, "_hits"}, hit_count, m_hits);
    check({tag, "_misses"}, miss_count, m_miss);
    step();
  endtask

  task automatic do_reset();
    bus.cpu_re = 1'b0;
    bus.cpu_we = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_cpu_rd", bus.cpu_rd, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_hits", hit_count, 32'd0);
    check("rst_misses", miss_count, 32'd0);
    step();
  endtask

  task automatic do_load(input logic [31:0] addr);
    int  i;
    bit  hit;
    i   = int'(addr[6:4]);
    hit = m_valid[i] && (m_line[i] == addr[31:4]);
    bus.cpu_a  = addr;
    bus.cpu_re = 1'b1;
    bus.cpu_we = 1'b0;
    if (!hit) begin
      for (int k = 0; k < 4; k++) exp_q.push_back({addr[31:4], 4'b0} + 32'(k * 4));
      @(negedge clk);
      check("miss_req_stall", 32'(bus.stall), 32'd1);
      step();
      m_miss++;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check("fill_stall", 32'(bus.stall), 32'd1);
        check("fill_mem_we", 32'(bus.mem_we), 32'd0);
        check("fill_mem_a", bus.mem_a, exp_q.pop_front());
        step();
      end
      m_valid[i] = 1'b1;
      m_line[i]  = addr[31:4];
    end
    @(negedge clk);
    check("load_stall", 32'(bus.stall), 32'd0);
    check("load_data", bus.cpu_rd, ref_mem[addr[13:2]]);
    step();
    m_hits++;
    bus.cpu_re = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input bit with_re);
    bus.cpu_a  = addr;
    bus.cpu_wd = data;
    bus.cpu_we = 1'b1;
    bus.cpu_re = with_re;
    @(negedge clk);
    check("store_stall", 32'(bus.stall), 32'd0);
    check("store_mem_we", 32'(bus.mem_we), 32'd1);
    check("store_mem_a", bus.mem_a, {addr[31:2], 2'b00});
    check("store_mem_wd", bus.mem_wd, data);
    check("store_cpu_rd", bus.cpu_rd, 32'd0);
    step();
    ref_mem[addr[13:2]] = data;
    bus.cpu_we = 1'b0;
    bus.cpu_re = 1'b0;
    check("store_mem_word", mem_arr[addr[13:2]], data);
  endtask

  task automatic do_idle();
    bus.cpu_re = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_a  = $urandom;
    @(negedge clk);
    check("idle_stall", 32'(bus.stall), 32'd0);
    check("idle_mem_we", 32'(bus.mem_we), 32'd0);
    check("idle_cpu_rd", bus.cpu_rd, 32'd0);
    step();
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'h1000 + 32'($urandom_range(0, 3) << 7) + 32'($urandom_range(0, 31) << 2)
           + 32'($urandom_range(0, 3));
  endfunction

  initial begin
    bus.cpu_a  = '0;
    bus.cpu_re = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_wd = '0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
    model_reset();
    step();
    mem_init = 1'b0;
    do_reset();
    do_idle();

    // 1-2: cold miss then hit in the same line
    do_load(32'h1000);
    check("t1_data_word", ref_mem[32'h400], 32'hA0);
    check_counters("t1");
    check("t1_miss_one", miss_count, 32'd1);
    do_load(32'h1008);
    check_counters("t2");

    // 3: write hit then load
    do_store(32'h1004, 32'hDEAD_BEEF, 1'b0);
    do_load(32'h1004);
    check_counters("t3");

    // 4: write miss (no allocate) then load miss
    do_store(32'h2000, 32'h1234_5678, 1'b0);
    do_load(32'h2000);
    check_counters("t4");

    // 5: conflicting tags on one index
    do_reset();
    do_load(32'h1000);
    do_load(32'h1080);
    do_load(32'h1000);
    check_counters("t5");
    check("t5_miss_three", miss_count, 32'd3);

    // 6: reset in the second fill cycle aborts the fill
    bus.cpu_a  = 32'h3000;
    bus.cpu_re = 1'b1;
    step();
    step();
    do_reset();
    do_load(32'h3000);
    check_counters("t6");

    // store with load asserted counts nothing
    do_store(32'h3004, 32'hCAFE_F00D, 1'b1);
    check_counters("we_re");

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op < 6) do_load(rand_addr());
      else if (op < 9) do_store(rand_addr(), $urandom, bit'($urandom_range(0, 1)));
      else do_idle();
      if (n % 25 == 0) check_counters("rand");
    end
    check_counters("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-through, no-write-allocate data cache between the CPU memory stage and the byte-addressed data memory. Read hits return a word combinationally in the same cycle. Read misses stall the CPU while a 4-word line is fetched from data memory one word per cycle. Writes go straight through to data memory every time, and also update the cache on a hit.

## Interface
- `A_WIDTH`, 32, address width on both the CPU and memory sides.
- `SETS`, 8, number of lines; power of two, at least 2.
- `CLK`  in  1  clock; all state updates on posedge.
- `RST`  in  1  synchronous reset, active-high.
- `CPU_A`  in  A_WIDTH  byte address; bits [1:0] are ignored (treated as 00).
- `CPU_RE`  in  1  load request.
- `CPU_WE`  in  1  store request.
- `CPU_WD`  in  32  store data.
- `CPU_RD`  out  32  load data; valid when CPU_RE=1 and STALL=0.
- `STALL`  out  1  CPU must hold all CPU_* inputs while high.
- `MEM_A`  out  A_WIDTH  address to data memory; bits [1:0] always 00.
- `MEM_WE`  out  1  data memory write enable.
- `MEM_WD`  out  32  data memory write data.
- `MEM_RD`  in  32  data memory read data; combinational from MEM_A, little-endian word.
- `HIT_COUNT`  out  32  read hits since reset; saturates at 0xFFFFFFFF.
- `MISS_COUNT`  out  32  read misses since reset; saturates.

## Operation

**Address split**
- Word offset = A[3:2].
- Index = A[4+log2(SETS)-1:4].
- Tag = remaining upper bits.

**Storage**
- Per line: valid bit, tag, and 4×32-bit data words.

**FSM states**
- IDLE:
  - Read hit (CPU_RE=1, CPU_WE=0, line valid, tags equal): CPU_RD = the cached word, STALL=0, HIT_COUNT increments.
  - Read miss: STALL=1, MISS_COUNT increments once, go to FILL with cnt=0.
  - Write (CPU_WE=1):
    - MEM_WE=1, MEM_A={CPU_A[A_WIDTH-1:2],00}, MEM_WD=CPU_WD, STALL=0.
    - On a hit, the cached word is replaced with CPU_WD at the same edge.
    - On a miss, no allocation happens; cache state is unchanged.
    - CPU_WE=1 with CPU_RE=1 is handled as a write only, with no read and no counter change.
  - Neither request: MEM_WE=0, no state change.
- FILL:
  - STALL=1 and MEM_WE=0.
  - MEM_A = {tag, index, cnt, 00} of the held CPU_A.
  - At each edge, MEM_RD is written into line word cnt and cnt increments.
  - At the edge where cnt=3: the tag is written, valid is set, and the FSM returns to IDLE.
  - The held read then hits in IDLE. That hit counts in HIT_COUNT as well, so one missed load counts 1 miss and 1 hit.
- Eviction: a fill overwrites the indexed line unconditionally. No writeback is needed because the cache is write-through.
- CPU_RD = 0 whenever the cycle is not a read hit in IDLE.
- In IDLE with no write, MEM_A follows CPU_A with bits [1:0] forced to 00; its value is don't-care.

## Timing
**Reset values**
- After a reset edge: state IDLE, cnt 0, all valid bits 0, HIT_COUNT=0, MISS_COUNT=0.
- Tags and data are not reset.
- Outputs with no request present: STALL=0, MEM_WE=0, CPU_RD=0.

**Latency**
- Read hit: 0 cycles; data is valid in the request cycle.
- Read miss:
  - STALL is high in the request cycle plus 4 FILL cycles, 5 cycles in total.
  - Data appears on CPU_RD in cycle 6, with STALL=0.
- Write: 0 stall cycles. Data memory captures the write at the same edge the cache updates.

**Handshake**
- A request is accepted at the first posedge where STALL=0.
- The CPU must not change CPU_* inputs while STALL=1.

**Boundaries**
- Reset during FILL:
  - Aborts the fill; the FSM goes to IDLE.
  - The line stays invalid; any partially written words are discarded.
  - Counters are cleared.
- Reset takes priority over any simultaneous request.
- Counters saturate and never wrap.
- Back-to-back misses to different indices each take the full 5 stall cycles; there is no overlap.
- Back-to-back misses to the same index replace the line.
- Address wrap: MEM_A arithmetic is a concatenation only, never an adder, so a line never crosses a line boundary.

## Test plan
1. Reset, then load word 0x1000 with memory words at 0x1000-0x100C = 0xA0,0xA1,0xA2,0xA3.
   - Required: STALL high for 5 cycles, MEM_A steps 0x1000, 0x1004, 0x1008, 0x100C.
   - Required: cycle 6 CPU_RD=0xA0, MISS_COUNT=1, HIT_COUNT=1.
2. After test 1, load 0x1008.
   - Required: same-cycle CPU_RD=0xA2, STALL=0, HIT_COUNT=2.
3. Store 0xDEADBEEF to 0x1004 (hit), then load 0x1004.
   - Required: MEM_WE=1 with MEM_A=0x1004 in the store cycle; the load hits with 0xDEADBEEF; memory word 0x1004 = 0xDEADBEEF.
4. Store 0x12345678 to 0x2000 (miss), then load 0x2000.
   - Required: the store takes no stall; the load misses (5 stall cycles) and returns 0x12345678.
5. With SETS=8, load 0x1000, then 0x1080 (same index, different tag), then 0x1000.
   - Required: three misses, MISS_COUNT=3.
6. Load miss to 0x3000, assert RST during the 2nd FILL cycle, release, then load 0x3000.
   - Required: STALL=0 and counters 0 after reset; the load misses again with a full 5-cycle fill and returns the correct data.
